regfile: RTL
============

// Module: regfile
// PURPOSE
//  - General-purpose register file for the 5-stage MIPS pipeline.
//  - Consumer end of the writeback interface: takes the wb_wdata / wb_wd / wb_wreg
//    triple from the MEM/WB register as its write port.
//  - Serves two read ports to the ID stage for rs/rt operand fetch.
//  - $0 is hardwired to zero; reads are combinational, writes are clocked.
// PARAMETERS
//  DATA_W    32  register width in bits (matches `RegBus)
//  ADDR_W    5   register index width (matches `RegAddrBus)
//  NUM_REGS  32  number of architectural registers; must equal 2**ADDR_W
// PORTS
//  clk     in   1       clock; all state updates on posedge
//  rst     in   1       reset; synchronous, active-high (`RstEnable)
//  we      in   1       write enable, driven from wb_wreg
//  waddr   in   ADDR_W  write index, driven from wb_wd
//  wdata   in   DATA_W  write data, driven from wb_wdata
//  re1     in   1       read port 1 enable (rs)
//  raddr1  in   ADDR_W  read port 1 index
//  rdata1  out  DATA_W  read port 1 data, combinational
//  re2     in   1       read port 2 enable (rt)
//  raddr2  in   ADDR_W  read port 2 index
//  rdata2  out  DATA_W  read port 2 data, combinational
// BEHAVIOUR
//  - Reset: on posedge clk with rst=1, all NUM_REGS entries clear to `ZeroWord.
//    - While rst=1, rdata1/rdata2 = `ZeroWord regardless of the other inputs.
//    - A write presented in a reset cycle is dropped.
//  - Write: on posedge clk with rst=0, we=1, waddr!=0, mem[waddr] <= wdata.
//    - Visible to array reads from the next cycle; write latency is 1 cycle.
//    - A write to $0 is ignored, so mem[0] stays 0 forever.
//  - Read, per port n (priority order):
//    1. rst=1                       -> 0
//    2. re_n=0                      -> 0
//    3. raddr_n=0                   -> 0
//    4. bypass hit (see CONFIGURATION) -> wdata
//    5. otherwise                   -> mem[raddr_n]
//  - Both ports may read the same index in the same cycle; each sees the same value.
//  - Both ports may hit the bypass in the same cycle; each returns wdata.
//  - Width rules:
//    - No arithmetic is performed.
//    - Indices are used unmodified; there is no wrap-around, since NUM_REGS = 2**ADDR_W.
//    - X on waddr with we=0 must not corrupt any entry.
// CONFIGURATION
//  - Macro REGFILE_BYPASS_EN.
//  - Defined: write-to-read bypass is enabled.
//    - Hit condition: rst=0, we=1, waddr==raddr_n, waddr!=0, re_n=1.
//    - On a hit, rdata_n = wdata in the same cycle.
//    - An instruction in ID reading a register being written by the instruction in
//      WB gets the new value with no stall.
//  - Undefined: no bypass.
//    - In the same-cycle case rdata_n returns the old mem[raddr_n].
//    - The pipeline control must stall or forward for that hazard.
// STRUCTURE
//  - Shared header defines.v holds RegBus, RegAddrBus, RegNum, ZeroWord, NOPRegAddr,
//    RstEnable, WriteEnable, ReadEnable and ReadDisable.
//    - No new local literals are defined for these values.
//  - One sub-module: regfile_rd_port. It contains the priority mux and the bypass
//    compare for one read port.
//    - Instantiated twice.
//    - The bypass compare sits inside `ifdef REGFILE_BYPASS_EN.
//  - The storage array and the write logic stay in the top module.
// TESTING
//  1. Reset:
//     - Stimulus: preload mem[5]=32'hDEAD_BEEF, assert rst for 1 cycle, then read r5.
//     - Expect: rdata1=0; during rst, rdata1=rdata2=0 even with re=1.
//  2. Basic write/read:
//     - Stimulus: we=1, waddr=8, wdata=32'h1234_5678; next cycle re1=1, raddr1=8.
//     - Expect: rdata1=32'h1234_5678.
//  3. $0 write:
//     - Stimulus: we=1, waddr=0, wdata=32'hFFFF_FFFF; then read r0 on both ports.
//     - Expect: rdata1=rdata2=0, including in the write cycle with bypass defined.
//  4. Same-cycle hazard:
//     - Stimulus: mem[3]=32'h0000_0011; in one cycle we=1, waddr=3, wdata=32'h0000_0022,
//       re1=re2=1, raddr1=raddr2=3.
//     - Expect with REGFILE_BYPASS_EN: both ports 32'h22.
//     - Expect without the macro: both ports 32'h11; both ports read 32'h22 next cycle.
//  5. Read disable:
//     - Stimulus: mem[9]=32'hA5A5_A5A5, re2=0, raddr2=9.
//     - Expect: rdata2=0. Setting re2=1 gives rdata2=32'hA5A5_A5A5.
//  6. Reset mid-stream:
//     - Stimulus: write r4..r7 on consecutive cycles, asserting rst in the cycle of the
//       r6 write; release rst and write r7.
//     - Expect: r4=r5=r6=0 and r7=its written value.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-bus widths and enable/reset levels for the MIPS pipeline.
// Used by regfile and regfile_rd_port (optional write-to-read bypass: REGFILE_BYPASS_EN).
package regfile_pkg;
   localparam int           REG_BUS      = 32;
   localparam int           REG_ADDR_BUS = 5;
   localparam int           REG_NUM      = 32;
   localparam logic [31:0]  ZERO_WORD    = 32'h0000_0000;
   localparam logic [4:0]   NOP_REG_ADDR = 5'b00000;
   localparam logic         RST_ENABLE   = 1'b1;
   localparam logic         WRITE_ENABLE = 1'b1;
   localparam logic         READ_ENABLE  = 1'b1;
   localparam logic         READ_DISABLE = 1'b0;
endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: priority mux for one combinational read port of the register file.
// The writeback bypass compare exists only when REGFILE_BYPASS_EN is defined.
module regfile_rd_port
   import regfile_pkg::*;
#(
   parameter int DATA_W = REG_BUS,
   parameter int ADDR_W = REG_ADDR_BUS
) (
   input  logic              rst,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] mem_data,
   output logic [DATA_W-1:0] rdata
);
   logic hit;
`ifdef REGFILE_BYPASS_EN
   // raddr != 0 is already covered by the higher-priority zero case below
   assign hit = (we == WRITE_ENABLE) && (waddr == raddr);
`else
   logic unused_bypass;
   assign unused_bypass = &{1'b0, we, waddr, wdata};
   assign hit = 1'b0;
`endif
   always_comb begin
      rdata = (rst == RST_ENABLE || re == READ_DISABLE || raddr == ADDR_W'(NOP_REG_ADDR))
              ? DATA_W'(ZERO_WORD) : hit ? wdata : mem_data;
   end
endmodule

// File: rtl/regfile.sv
// regfile: 2-read/1-write MIPS register file, $0 hardwired to zero, clocked writes.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to the read ports.
module regfile
   import regfile_pkg::*;
#(
   parameter int DATA_W   = REG_BUS,
   parameter int ADDR_W   = REG_ADDR_BUS,
   parameter int NUM_REGS = REG_NUM
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re1,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1,
   input  logic              re2,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata2
);
   logic [DATA_W-1:0] mem [NUM_REGS];
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         for (int i = 0; i < NUM_REGS; i++) mem[i] <= DATA_W'(ZERO_WORD);
      end else if (we == WRITE_ENABLE && waddr != ADDR_W'(NOP_REG_ADDR)) begin
         mem[waddr] <= wdata;
      end
   end
   regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd1 (
      .rst(rst), .re(re1), .raddr(raddr1), .we(we), .waddr(waddr), .wdata(wdata),
      .mem_data(mem[raddr1]), .rdata(rdata1)
   );
   regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd2 (
      .rst(rst), .re(re2), .raddr(raddr2), .we(we), .waddr(waddr), .wdata(wdata),
      .mem_data(mem[raddr2]), .rdata(rdata2)
   );
endmodule
